// File: rtl/ram_sp_sweep_clear.sv
// Single-port synchronous RAM with a registered read port and a one-word-per-cycle
// clear engine. The caller polls busy before issuing accesses.
module ram_sp_sweep_clear #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              busy,
  output logic              rejected
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_PTR  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);
  localparam logic [ADDR_W:0]   DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

  state_t            state_r;
  state_t            state_nxt_s;
  logic [ADDR_W-1:0] clr_ptr_r;
  logic [ADDR_W-1:0] clr_ptr_nxt_s;
  logic [DATA_W-1:0] data_out_r;
  logic              rd_valid_r;
  logic              busy_r;
  logic              rejected_r;

  logic [DATA_W-1:0] mem_r [DEPTH];

  logic              mem_we_s;
  logic [ADDR_W-1:0] mem_waddr_s;
  logic [DATA_W-1:0] mem_wdata_s;
  logic              rd_fire_s;
  logic              rej_s;
  logic              addr_ok_s;
  logic [DATA_W-1:0] rd_data_s;

  // Out-of-range addresses only exist when DEPTH is not a power of two
  assign addr_ok_s = ({1'b0, addr} < DEPTH_LIM);
  assign rd_data_s = addr_ok_s ? mem_r[addr] : {DATA_W{1'b0}};

  // Next-state, clear pointer, memory write port and request arbitration
  always_comb begin
    state_nxt_s   = state_r;
    clr_ptr_nxt_s = clr_ptr_r;
    mem_we_s      = 1'b0;
    mem_waddr_s   = clr_ptr_r;
    mem_wdata_s   = {DATA_W{1'b0}};
    rd_fire_s     = 1'b0;
    rej_s         = 1'b0;
    case (state_r)
      ST_CLEAR: begin
        mem_we_s = 1'b1;
        rej_s    = wr_en | rd_en;
        if (clr_ptr_r == LAST_PTR) begin
          state_nxt_s   = ST_IDLE;
          clr_ptr_nxt_s = {ADDR_W{1'b0}};
        end else begin
          clr_ptr_nxt_s = clr_ptr_r + PTR_ONE;
        end
      end
      ST_IDLE: begin
        if (clear) begin
          state_nxt_s   = ST_CLEAR;
          clr_ptr_nxt_s = {ADDR_W{1'b0}};
          rej_s         = wr_en | rd_en;
        end else if (wr_en) begin
          mem_we_s    = addr_ok_s;
          mem_waddr_s = addr;
          mem_wdata_s = data_in;
          rej_s       = rd_en;
        end else if (rd_en) begin
          rd_fire_s = 1'b1;
        end else begin
          rd_fire_s = 1'b0;
        end
      end
      default: begin
        state_nxt_s   = ST_CLEAR;
        clr_ptr_nxt_s = {ADDR_W{1'b0}};
      end
    endcase
  end

  // FSM state and clear pointer; reset starts a fresh sweep from address 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_CLEAR;
      clr_ptr_r <= {ADDR_W{1'b0}};
    end else begin
      state_r   <= state_nxt_s;
      clr_ptr_r <= clr_ptr_nxt_s;
    end
  end

  // Registered outputs; data_out only changes when a read completes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out_r <= {DATA_W{1'b0}};
      rd_valid_r <= 1'b0;
      busy_r     <= 1'b1;
      rejected_r <= 1'b0;
    end else begin
      rd_valid_r <= rd_fire_s;
      busy_r     <= (state_nxt_s == ST_CLEAR);
      rejected_r <= rej_s;
      if (rd_fire_s) begin
        data_out_r <= rd_data_s;
      end
    end
  end

  // Storage array, deliberately unreset; the sweep initialises it
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[mem_waddr_s] <= mem_wdata_s;
    end
  end

  assign data_out = data_out_r;
  assign rd_valid = rd_valid_r;
  assign busy     = busy_r;
  assign rejected = rejected_r;

endmodule
